dot_product_ctrl: RTL and testbench

DOT_PRODUCT_CTRL -- requirements
Module: dot_product_ctrl

---
 rtl/dot_product_ctrl_pkg.sv | 15 +
 rtl/dot_product_ctrl_addr_counter.sv | 40 ++++
 rtl/dot_product_ctrl.sv | 124 ++++++++++++
 tb/tb_dot_product_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_product_ctrl_pkg.sv
// Shared types and widths for the dot-product sequencer and its address counter.
package dot_product_ctrl_pkg;

    localparam int MAC_IN_W  = 8;
    localparam int MAC_ACC_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/dot_product_ctrl_addr_counter.sv
// Element address generator: latches the vector length, steps the read index,
// and flags the last element and the empty-vector case.
module dp_addr_counter
    import dot_product_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic              i_inc,
    input  logic [ADDR_W-1:0] i_len,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_len_zero,
    output logic              o_tc
);

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] w_last;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr <= '0;
            r_len  <= '0;
        end else if (i_load) begin
            r_addr <= '0;
            r_len  <= i_len;
        end else if (i_inc) begin
            r_addr <= r_addr + ADDR_W'(1);
        end
    end

    // w_last wraps for len=0, but o_len_zero takes precedence in the controller
    assign w_last     = r_len - ADDR_W'(1);
    assign o_addr     = r_addr;
    assign o_len_zero = (r_len == '0);
    assign o_tc       = (r_addr == w_last);

endmodule

// File: rtl/dot_product_ctrl.sv
// Sequences operand reads into an external MAC and presents the accumulated
// dot product with a valid/ready handshake.
module dot_product_ctrl
    import dot_product_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter bit RELU   = 1'b0
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_start,
    input  logic [ADDR_W-1:0]           i_len,
    output logic                        o_busy,
    output logic                        o_rd_en,
    output logic [ADDR_W-1:0]           o_rd_addr,
    input  logic signed [MAC_IN_W-1:0]  i_act_in,
    input  logic signed [MAC_IN_W-1:0]  i_wt_in,
    output logic                        o_mac_clr,
    output logic                        o_mac_en,
    output logic signed [MAC_IN_W-1:0]  o_mac_a,
    output logic signed [MAC_IN_W-1:0]  o_mac_b,
    input  logic signed [MAC_ACC_W-1:0] i_mac_out,
    output logic signed [MAC_ACC_W-1:0] o_result,
    output logic                        o_result_valid,
    input  logic                        i_result_ready
);

    state_t            r_state;
    state_t            w_next;
    logic              w_load;
    logic              w_inc;
    logic              w_tc;
    logic              w_len_zero;
    logic [ADDR_W-1:0] w_addr;
    logic              w_rd_en;
    logic              w_mac_en;
    logic              w_mac_clr;
    logic              w_valid;
    logic              w_clamp;

    dp_addr_counter #(.ADDR_W(ADDR_W)) u_addr_counter (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_load),
        .i_inc      (w_inc),
        .i_len      (i_len),
        .o_addr     (w_addr),
        .o_len_zero (w_len_zero),
        .o_tc       (w_tc)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_inc     = 1'b0;
        w_rd_en   = 1'b0;
        w_mac_en  = 1'b0;
        w_mac_clr = 1'b0;
        w_valid   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_load = 1'b1;
                    w_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_mac_clr = 1'b1;
                if (w_len_zero) begin
                    w_next = ST_DONE;
                end else begin
                    w_rd_en = 1'b1;
                    if (w_tc) begin
                        w_next = ST_DRAIN;
                    end else begin
                        w_inc  = 1'b1;
                        w_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                w_rd_en  = 1'b1;
                w_mac_en = 1'b1;
                if (w_tc) w_next = ST_DRAIN;
                else      w_inc  = 1'b1;
            end
            ST_DRAIN: begin
                w_mac_en = 1'b1;
                w_next   = ST_DONE;
            end
            ST_DONE: begin
                w_valid = 1'b1;
                if (i_result_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        // Reset forces the idle-looking outputs immediately, with the MAC held clear
        if (i_reset) begin
            w_load    = 1'b0;
            w_inc     = 1'b0;
            w_rd_en   = 1'b0;
            w_mac_en  = 1'b0;
            w_mac_clr = 1'b1;
            w_valid   = 1'b0;
        end
    end

    assign w_clamp        = RELU && i_mac_out[MAC_ACC_W-1];
    assign o_busy         = !i_reset && (r_state != ST_IDLE);
    assign o_rd_en        = w_rd_en;
    assign o_rd_addr      = i_reset ? '0 : w_addr;
    assign o_mac_clr      = w_mac_clr;
    assign o_mac_en       = w_mac_en;
    assign o_mac_a        = i_act_in;
    assign o_mac_b        = i_wt_in;
    assign o_result_valid = w_valid;
    assign o_result       = (w_valid && !w_clamp) ? i_mac_out : '0;

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Bench for dot_product_ctrl: two instances (plain and ReLU) share one operand
// memory; each feeds its own MAC; results are checked against a sum-of-products.
module tb_dot_product_ctrl;

    localparam int AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] len   = '0;
    logic          ready = 1'b0;

    logic                busy0, busy1, rd_en0, rd_en1, clr0, clr1, en0, en1, vld0, vld1;
    logic [AW-1:0]       addr0, addr1;
    logic signed [7:0]   act, wt, a0, b0, a1, b1;
    logic signed [23:0]  acc0, acc1, res0, res1;

    byte mem_a [0:255];
    byte mem_w [0:255];

    int n_cmp = 0;
    int n_bad = 0;

    dot_product_ctrl #(.ADDR_W(AW), .RELU(1'b0)) u_dut0 (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_len(len),
        .o_busy(busy0), .o_rd_en(rd_en0), .o_rd_addr(addr0),
        .i_act_in(act), .i_wt_in(wt),
        .o_mac_clr(clr0), .o_mac_en(en0), .o_mac_a(a0), .o_mac_b(b0),
        .i_mac_out(acc0), .o_result(res0), .o_result_valid(vld0),
        .i_result_ready(ready)
    );

    dot_product_ctrl #(.ADDR_W(AW), .RELU(1'b1)) u_dut1 (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_len(len),
        .o_busy(busy1), .o_rd_en(rd_en1), .o_rd_addr(addr1),
        .i_act_in(act), .i_wt_in(wt),
        .o_mac_clr(clr1), .o_mac_en(en1), .o_mac_a(a1), .o_mac_b(b1),
        .i_mac_out(acc1), .o_result(res1), .o_result_valid(vld1),
        .i_result_ready(ready)
    );

    // Vector memory with one cycle read latency
    always @(posedge clk) begin
        if (rd_en0) begin
            act <= mem_a[addr0];
            wt  <= mem_w[addr0];
        end
    end

    // External MACs
    always @(posedge clk) begin
        if (clr0)     acc0 <= '0;
        else if (en0) acc0 <= acc0 + a0 * b0;
        if (clr1)     acc1 <= '0;
        else if (en1) acc1 <= acc1 + a1 * b1;
    end

    task automatic load_const(input int n, input int va, input int vw);
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = (i < n) ? byte'(va) : byte'(0);
            mem_w[i] = (i < n) ? byte'(vw) : byte'(0);
        end
    endtask

    task automatic load_random();
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = byte'($urandom_range(255));
            mem_w[i] = byte'($urandom_range(255));
        end
    endtask

    task automatic do_run(input string nm, input int n, input int hold);
        int exp_sum, exp_relu, lat, rd_cnt, en_cnt, proto_bad, addr_bad, unstable;
        bit got, prev_rd;
        logic signed [23:0] held0, held1;
        exp_sum = 0;
        for (int i = 0; i < n; i++) exp_sum += int'(mem_a[i]) * int'(mem_w[i]);
        exp_relu = (exp_sum < 0) ? 0 : exp_sum;
        rd_cnt = 0; en_cnt = 0; proto_bad = 0; addr_bad = 0; lat = -1;
        got = 1'b0; prev_rd = 1'b0;
        start = 1'b1;
        len   = AW'(n);
        for (int c = 1; c <= n + 6 && !got; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (rd_en0) begin
                if (addr0 !== AW'(rd_cnt)) addr_bad++;
                rd_cnt++;
            end
            if (en0 !== prev_rd) proto_bad++;
            if (en0 && clr0) proto_bad++;
            if (rd_en1 !== rd_en0 || en1 !== en0) proto_bad++;
            if (en0) en_cnt++;
            prev_rd = rd_en0;
            if (vld0) begin
                got = 1'b1;
                lat = c;
            end
        end
        n_cmp++;
        if (lat !== n + 2) begin
            n_bad++;
            $display("FAIL %s latency: got %0d required %0d", nm, lat, n + 2);
        end
        n_cmp++;
        if (res0 !== 24'(exp_sum)) begin
            n_bad++;
            $display("FAIL %s result: got %0d required %0d", nm, res0, exp_sum);
        end
        n_cmp++;
        if (vld1 !== 1'b1 || res1 !== 24'(exp_relu)) begin
            n_bad++;
            $display("FAIL %s relu_result: got %0d (valid %b) required %0d", nm, res1, vld1, exp_relu);
        end
        n_cmp++;
        if (rd_cnt !== n || en_cnt !== n || addr_bad !== 0 || proto_bad !== 0) begin
            n_bad++;
            $display("FAIL %s strobes: rd=%0d en=%0d addr_err=%0d proto_err=%0d required rd=en=%0d errs=0",
                     nm, rd_cnt, en_cnt, addr_bad, proto_bad, n);
        end
        held0 = res0; held1 = res1; unstable = 0;
        for (int h = 0; h < hold; h++) begin
            start = 1'b1;
            @(posedge clk); #1;
            if (vld0 !== 1'b1 || res0 !== held0 || res1 !== held1 || busy0 !== 1'b1) unstable++;
        end
        n_cmp++;
        if (unstable !== 0) begin
            n_bad++;
            $display("FAIL %s hold_stable: %0d unstable cycles required 0", nm, unstable);
        end
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        start = 1'b0;
        unstable = 0;
        for (int k = 0; k < 3; k++) begin
            if (busy0 !== 1'b0 || vld0 !== 1'b0 || busy1 !== 1'b0) unstable++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (unstable !== 0) begin
            n_bad++;
            $display("FAIL %s exit_idle: %0d busy/valid cycles after ready required 0", nm, unstable);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({busy0, rd_en0, en0, vld0, clr0} !== 5'b00001 || addr0 !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: busy/rd/en/vld/clr=%b addr=%0d required 00001 addr=0",
                     {busy0, rd_en0, en0, vld0, clr0}, addr0);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (clr0 !== 1'b0 || busy0 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: clr=%b busy=%b required 0 0", clr0, busy0);
        end
    endtask

    task automatic test_basic();
        load_const(0, 0, 0);
        mem_a[0] = 15;  mem_w[0] = 10;
        mem_a[1] = 25;  mem_w[1] = 20;
        do_run("basic_len2", 2, 0);
    endtask

    task automatic test_len_zero();
        load_random();
        do_run("len0", 0, 1);
    endtask

    task automatic test_len_one();
        load_random();
        do_run("len1", 1, 0);
    endtask

    task automatic test_negative();
        load_const(0, 0, 0);
        mem_a[0] = -100; mem_w[0] = -50;
        mem_a[1] = -128; mem_w[1] = 127;
        mem_a[2] = 1;    mem_w[2] = 1;
        do_run("negative_len3", 3, 0);
    endtask

    task automatic test_len_max();
        load_const(255, -128, -128);
        do_run("len255", 255, 0);
    endtask

    task automatic test_hold();
        load_random();
        do_run("hold_ready", 4, 5);
    endtask

    task automatic test_abort();
        bit found;
        int late;
        load_random();
        found = 1'b0;
        start = 1'b1;
        len   = AW'(10);
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (rd_en0 && addr0 == AW'(3)) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL abort_reach: rd_addr=3 not seen, got addr %0d", addr0);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({busy0, rd_en0, en0, vld0, clr0} !== 5'b00001 || addr0 !== '0) begin
            n_bad++;
            $display("FAIL abort_outputs: busy/rd/en/vld/clr=%b addr=%0d required 00001 addr=0",
                     {busy0, rd_en0, en0, vld0, clr0}, addr0);
        end
        reset = 1'b0;
        late = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (vld0 || busy0 || rd_en0) late++;
        end
        n_cmp++;
        if (late !== 0) begin
            n_bad++;
            $display("FAIL abort_quiet: %0d active cycles after abort required 0", late);
        end
        load_const(0, 0, 0);
        mem_a[0] = 15;  mem_w[0] = 10;
        mem_a[1] = 25;  mem_w[1] = 20;
        do_run("after_abort", 2, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            load_random();
            do_run("random", int'($urandom_range(20)), int'($urandom_range(3)));
        end
    endtask

    task automatic test_back_to_back();
        load_random();
        do_run("b2b_a", 3, 0);
        do_run("b2b_b", 5, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_len_one();
        test_negative();
        test_len_max();
        test_hold();
        test_abort();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
